// File: rtl/interleave_pwm_n_if.sv
// Control/status bundle between the modulation controller and the interleaved PWM core.
// The controller drives the master side; the PWM core implements the slave side.
interface interleave_pwm_n_if #(
  parameter int LEVEL_COUNT = 4,
  parameter int BIT_WIDTH   = 16
);
  logic                     Enable;
  logic                     Mode;
  logic [BIT_WIDTH-1:0]     Compare;
  logic [BIT_WIDTH-1:0]     PWMMaxCount;
  logic [BIT_WIDTH-1:0]     TriangleStepSize;
  logic [BIT_WIDTH-1:0]     PhaseOffset;
  logic [BIT_WIDTH-1:0]     DeadTimeCount;
  logic [2*LEVEL_COUNT-1:0] S;
  logic                     PeriodSync;
  logic                     ConfigError;

  modport master (
    output Enable, Mode, Compare, PWMMaxCount, TriangleStepSize, PhaseOffset, DeadTimeCount,
    input  S, PeriodSync, ConfigError
  );

  modport slave (
    input  Enable, Mode, Compare, PWMMaxCount, TriangleStepSize, PhaseOffset, DeadTimeCount,
    output S, PeriodSync, ConfigError
  );
endinterface

// File: rtl/interleave_pwm_n.sv
// N-channel interleaved PWM (phase- or level-shifted) with dead-time complementary pairs.
// Define INTERLEAVE_PWM_DOUBLE_UPDATE_EN to also reload Compare at the carrier peak.
module interleave_pwm_n #(
  parameter int LEVEL_COUNT = 4,
  parameter int BIT_WIDTH   = 16
) (
  input  logic               MClk,
  input  logic               Rst,
  interleave_pwm_n_if.slave  bus
);
  localparam int PW = BIT_WIDTH + 2;
  localparam int CW = BIT_WIDTH + 6;

  typedef enum logic [1:0] {ST_OFF, ST_HIGH, ST_LOW, ST_DEAD} ch_state_e;

  logic [PW-1:0]        p_q, p_d;
  logic [BIT_WIDTH-1:0] cmp_q, cmp_d, max_q, max_d, step_q, step_d;
  logic [BIT_WIDTH-1:0] off_q, off_d, dead_q, dead_d;
  logic                 sync_q, sync_d, err_q, err_d;
  logic                 cfg_bad, run, wrap, load;
  logic [CW-1:0]        two_m, sum, c0;
  logic [2*LEVEL_COUNT-1:0] s_w;
`ifdef INTERLEAVE_PWM_DOUBLE_UPDATE_EN
  logic                 peak_seen_q, peak_seen_d, peak;
`endif

  always_comb begin
    two_m   = CW'({max_q, 1'b0});
    cfg_bad = (max_q == '0) || (step_q == '0);
    run     = bus.Enable && !cfg_bad;
    sum     = CW'(p_q) + CW'(step_q);
    wrap    = (sum >= two_m);
    c0      = (CW'(p_q) <= CW'(max_q)) ? CW'(p_q) : two_m - CW'(p_q);
    p_d     = '0;
    sync_d  = 1'b0;
    if (run) begin
      sync_d = wrap;
      p_d    = wrap ? PW'(sum - two_m) : PW'(sum);
    end
    // Shadow registers follow the inputs while idle and latch at period start.
    load   = !bus.Enable || sync_q;
    cmp_d  = cmp_q;
    max_d  = max_q;
    step_d = step_q;
    off_d  = off_q;
    dead_d = dead_q;
    if (load) begin
      cmp_d  = bus.Compare;
      max_d  = bus.PWMMaxCount;
      step_d = bus.TriangleStepSize;
      off_d  = bus.PhaseOffset;
      dead_d = bus.DeadTimeCount;
    end
`ifdef INTERLEAVE_PWM_DOUBLE_UPDATE_EN
    peak        = run && !peak_seen_q && (CW'(p_q) >= CW'(max_q));
    peak_seen_d = (!run || sync_d) ? 1'b0 : (peak_seen_q || peak);
    if (peak) cmp_d = bus.Compare;
`endif
    err_d = (max_d == '0) || (step_d == '0);
  end

  always_ff @(posedge MClk) begin
    if (Rst) begin
      p_q    <= '0;
      cmp_q  <= '0;
      max_q  <= '0;
      step_q <= '0;
      off_q  <= '0;
      dead_q <= '0;
      sync_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef INTERLEAVE_PWM_DOUBLE_UPDATE_EN
      peak_seen_q <= 1'b0;
`endif
    end else begin
      p_q    <= p_d;
      cmp_q  <= cmp_d;
      max_q  <= max_d;
      step_q <= step_d;
      off_q  <= off_d;
      dead_q <= dead_d;
      sync_q <= sync_d;
      err_q  <= err_d;
`ifdef INTERLEAVE_PWM_DOUBLE_UPDATE_EN
      peak_seen_q <= peak_seen_d;
`endif
    end
  end

  for (genvar gi = 0; gi < LEVEL_COUNT; gi++) begin : g_ch
    localparam logic [CW-1:0] IDX = CW'(gi);
    ch_state_e            st_q, st_d;
    logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tgt_q, tgt_d;
    logic [CW-1:0]        ph_raw, ph, tri_v, lvl_v;
    logic                 raw_i, restart;

    always_comb begin
      ph_raw = CW'(p_q) + IDX * CW'(off_q);
      ph     = (ph_raw >= two_m) ? ph_raw - two_m : ph_raw;
      tri_v  = (ph <= CW'(max_q)) ? ph : two_m - ph;
      lvl_v  = c0 + IDX * CW'(max_q);
      raw_i  = bus.Mode ? (CW'(cmp_q) > lvl_v) : (CW'(cmp_q) > tri_v);
    end

    // target holds the side the channel is on or heading to; a raw mismatch is an edge.
    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      restart = 1'b0;
      if (!run) begin
        st_d  = ST_OFF;
        cnt_d = '0;
        tgt_d = 1'b0;
      end else begin
        case (st_q)
          ST_OFF:          restart = 1'b1;
          ST_HIGH, ST_LOW: restart = (raw_i != tgt_q);
          ST_DEAD: begin
            if (raw_i != tgt_q)   restart = 1'b1;
            else if (cnt_q == '0) st_d = tgt_q ? ST_HIGH : ST_LOW;
            else                  cnt_d = cnt_q - BIT_WIDTH'(1);
          end
          default:         st_d = ST_OFF;
        endcase
        if (restart) begin
          tgt_d = raw_i;
          if (dead_q == '0) begin
            st_d  = raw_i ? ST_HIGH : ST_LOW;
            cnt_d = '0;
          end else begin
            st_d  = ST_DEAD;
            cnt_d = dead_q - BIT_WIDTH'(1);
          end
        end
      end
    end

    always_ff @(posedge MClk) begin
      if (Rst) begin
        st_q  <= ST_OFF;
        cnt_q <= '0;
        tgt_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        tgt_q <= tgt_d;
      end
    end

    assign s_w[2*gi]   = (st_q == ST_HIGH);
    assign s_w[2*gi+1] = (st_q == ST_LOW);
  end

  assign bus.S           = s_w;
  assign bus.PeriodSync  = sync_q;
  assign bus.ConfigError = err_q;
endmodule
